// File: rtl/fetch_pkg.sv
// Shared types and instruction-field layout for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DRAIN
    } state_t;

    localparam int INSTR_W  = 32;
    localparam int COND_LO  = 28;
    localparam int OP_LO    = 26;
    localparam int FUNCT_LO = 20;
    localparam int RN_LO    = 16;
    localparam int RD_LO    = 12;
    localparam int IMM_LO   = 0;

    // Low address bits cleared on every redirect so the PC stays word aligned.
    localparam logic [1:0] WORD_LSB_MASK = 2'b11;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit ARM-subset instruction word into decoder fields.
module instr_field_split
    import fetch_pkg::*;
(
    input  logic [INSTR_W-1:0] word_i,
    output logic [3:0]         cond_o,
    output logic [1:0]         op_o,
    output logic [5:0]         funct_o,
    output logic [3:0]         rn_o,
    output logic [3:0]         rd_o,
    output logic [11:0]        imm12_o
);

    assign cond_o  = word_i[COND_LO  +: 4];
    assign op_o    = word_i[OP_LO    +: 2];
    assign funct_o = word_i[FUNCT_LO +: 6];
    assign rn_o    = word_i[RN_LO    +: 4];
    assign rd_o    = word_i[RD_LO    +: 4];
    assign imm12_o = word_i[IMM_LO   +: 12];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, imem req/valid fetch, one-deep issue buffer
// toward the decoder with branch/flush redirect and in-flight response draining.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [3:0]         cond,
    output logic [1:0]         op,
    output logic [5:0]         funct,
    output logic [3:0]         rn,
    output logic [3:0]         rd,
    output logic [11:0]        imm12,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_plus8,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               flush,
    output logic [CNT_W-1:0]   issued_cnt
);

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], a[1:0] & ~WORD_LSB_MASK};
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   drain_addr_q, drain_addr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0]   pc8_q, pc8_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   redirect;

    assign redirect = align_word(branch_target);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_pc_d   = instr_pc_q;
        pc8_d        = pc8_q;
        instr_d      = instr_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_valid) begin
                    // A response arriving with a flush belongs to the old path.
                    if (!flush) begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        pc8_d      = pc_q + ADDR_W'(8);
                        pc_d       = pc_q + ADDR_W'(4);
                        state_d    = S_ISSUE;
                    end
                end else if (flush) begin
                    drain_addr_d = pc_q;
                    state_d      = S_DRAIN;
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_FETCH;
                end else if (instr_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_FETCH;
                    if (branch_taken) pc_d = redirect;
                end
            end
            S_DRAIN: begin
                if (imem_valid) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) pc_d = redirect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            instr_pc_q   <= '0;
            pc8_q        <= '0;
            instr_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_pc_q   <= instr_pc_d;
            pc8_q        <= pc8_d;
            instr_q      <= instr_d;
            cnt_q        <= cnt_d;
        end
    end

    // While draining, the address of the abandoned request stays on the bus.
    always_comb begin
        imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
        imem_addr = '0;
        if (state_q == S_FETCH)      imem_addr = pc_q;
        else if (state_q == S_DRAIN) imem_addr = drain_addr_q;
    end

    assign instr_valid = (state_q == S_ISSUE);
    assign instr_pc    = instr_pc_q;
    assign pc_plus8    = pc8_q;
    assign issued_cnt  = cnt_q;

    instr_field_split u_split (
        .word_i  (instr_q),
        .cond_o  (cond),
        .op_o    (op),
        .funct_o (funct),
        .rn_o    (rn),
        .rd_o    (rd),
        .imm12_o (imm12)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table-decoded memory image, scoreboard of expected
// instruction addresses, and hand sequences for branch, flush, reset and wrap.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    initial forever #5 clk = ~clk;

    // DUT0: default parameters
    logic        rst_n, imem_req, imem_valid, instr_valid, instr_ready;
    logic        branch_taken, flush;
    logic [31:0] imem_addr, imem_rdata, instr_pc, pc_plus8, branch_target;
    logic [3:0]  cond, rn, rd;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [11:0] imm12;
    logic [15:0] issued_cnt;

    // DUT2: wrap-around configuration
    logic        rst2_n, imem_req2, instr_valid2;
    logic [31:0] imem_addr2, instr_pc2, pc_plus8_2;
    logic [3:0]  cond2, rn2, rd2, issued_cnt2;
    logic [1:0]  op2;
    logic [5:0]  funct2;
    logic [11:0] imm12_2;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd),
        .imm12(imm12), .instr_pc(instr_pc), .pc_plus8(pc_plus8),
        .branch_taken(branch_taken), .branch_target(branch_target), .flush(flush),
        .issued_cnt(issued_cnt)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_valid(1'b1), .imem_rdata(32'hE082_1003), .instr_valid(instr_valid2),
        .instr_ready(1'b1), .cond(cond2), .op(op2), .funct(funct2), .rn(rn2), .rd(rd2),
        .imm12(imm12_2), .instr_pc(instr_pc2), .pc_plus8(pc_plus8_2),
        .branch_taken(1'b0), .branch_target(32'h0), .flush(1'b0),
        .issued_cnt(issued_cnt2)
    );

    typedef struct {
        logic [31:0] word;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] imm;
    } vec_t;

    vec_t        tbl[8];
    int          total = 0, passed = 0;
    logic [31:0] sb[$];
    logic [31:0] acc_log[$];
    logic [31:0] fetch_pc, drain_addr, p_target, br_pc;
    logic [15:0] exp_cnt;
    bit          drop_pending, p_ready, br_en, br_all, flushed;
    int          wait_cfg, wcnt, fmode, acc_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    function automatic logic [31:0] exp_fields(input logic [31:0] pc);
        vec_t v;
        v = tbl[pc[4:2]];
        return {v.cond, v.op, v.funct, v.rn, v.rd, v.imm};
    endfunction

    task automatic model_reset();
        sb.delete();
        fetch_pc     = 32'h0;
        drain_addr   = 32'h0;
        exp_cnt      = 16'h0;
        drop_pending = 1'b0;
        wcnt         = 0;
    endtask

    task automatic cyc();
        logic [31:0] ea, p;
        @(negedge clk);
        chk("issued_cnt", {48'h0, issued_cnt}, {48'h0, exp_cnt});
        ea = drop_pending ? drain_addr : fetch_pc;
        if (imem_req) chk("imem_addr", {32'h0, imem_addr}, {32'h0, ea});
        if (instr_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL sb_empty: instr_valid=1 with pc %0h, required no instruction", instr_pc);
            end else begin
                p = sb[0];
                chk("fields", {32'h0, cond, op, funct, rn, rd, imm12}, {32'h0, exp_fields(p)});
                chk("instr_pc", {32'h0, instr_pc}, {32'h0, p});
                chk("pc_plus8", {32'h0, pc_plus8}, {32'h0, p + 32'd8});
            end
        end
        // memory responder
        if (imem_req) begin
            if (wcnt >= wait_cfg) begin
                imem_valid = 1'b1;
                imem_rdata = tbl[imem_addr[4:2]].word;
                wcnt = 0;
            end else begin
                imem_valid = 1'b0;
                wcnt++;
            end
        end else begin
            imem_valid = 1'b0;
            wcnt = 0;
        end
        instr_ready   = p_ready;
        branch_target = p_target;
        flush = 1'b0;
        case (fmode)
            1: flush = imem_req && !imem_valid && !drop_pending && (wcnt == 1);
            2: flush = imem_req && imem_valid && !drop_pending;
            3: flush = instr_valid;
            default: flush = 1'b0;
        endcase
        if (flush) begin fmode = 0; flushed = 1'b1; end
        branch_taken = instr_valid && (br_all || (br_en && sb.size() > 0 && sb[0] == br_pc));
        // reference model update for the coming edge
        if (flush) begin
            if (instr_valid && sb.size() > 0) void'(sb.pop_front());
            if (imem_req) begin
                if (imem_valid) drop_pending = 1'b0;
                else begin
                    if (!drop_pending) drain_addr = ea;
                    drop_pending = 1'b1;
                end
            end
            fetch_pc = {branch_target[31:2], 2'b00};
        end else begin
            if (instr_valid && instr_ready && sb.size() > 0) begin
                acc_log.push_back(sb.pop_front());
                exp_cnt++;
                acc_n++;
                if (branch_taken) fetch_pc = {branch_target[31:2], 2'b00};
            end
            if (imem_req && imem_valid) begin
                if (drop_pending) drop_pending = 1'b0;
                else begin
                    sb.push_back(fetch_pc);
                    fetch_pc = fetch_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic run_accepts(input int n, input int budget, input string name);
        int start;
        start = acc_n;
        for (int i = 0; i < budget && acc_n < start + n; i++) cyc();
        if (acc_n < start + n) timeout(name);
    endtask

    task automatic wait_flush(input string name);
        flushed = 1'b0;
        for (int i = 0; i < 40 && !flushed; i++) cyc();
        if (!flushed) timeout(name);
    endtask

    initial begin
        logic [31:0] exp_pcs[6];
        int          n0;
        bit          seen;

        tbl[0] = '{32'hE082_1003, 4'hE, 2'd0, 6'h08, 4'h2, 4'h1, 12'h003};
        tbl[1] = '{32'hE591_2004, 4'hE, 2'd1, 6'h19, 4'h1, 4'h2, 12'h004};
        tbl[2] = '{32'h0A00_0005, 4'h0, 2'd2, 6'h20, 4'h0, 4'h0, 12'h005};
        tbl[3] = '{32'hFFFF_FFFF, 4'hF, 2'd3, 6'h3F, 4'hF, 4'hF, 12'hFFF};
        tbl[4] = '{32'h0000_0000, 4'h0, 2'd0, 6'h00, 4'h0, 4'h0, 12'h000};
        tbl[5] = '{32'h13A0_C0FF, 4'h1, 2'd0, 6'h3A, 4'h0, 4'hC, 12'h0FF};
        tbl[6] = '{32'h5C3E_7ABC, 4'h5, 2'd3, 6'h03, 4'hE, 4'h7, 12'hABC};
        tbl[7] = '{32'hA6D4_9123, 4'hA, 2'd1, 6'h2D, 4'h4, 4'h9, 12'h123};
        exp_pcs = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108};

        rst_n = 1'b0; rst2_n = 1'b0;
        imem_valid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; flush = 1'b0;
        p_ready = 1'b1; p_target = 32'h0; br_en = 1'b0; br_all = 1'b0; br_pc = 32'h0;
        wait_cfg = 0; fmode = 0; acc_n = 0; flushed = 1'b0;
        model_reset();

        #1;
        chk("rst_req", {63'h0, imem_req}, 64'h0);
        chk("rst_addr", {32'h0, imem_addr}, 64'h0);
        chk("rst_valid", {63'h0, instr_valid}, 64'h0);
        chk("rst_fields", {32'h0, cond, op, funct, rn, rd, imm12}, 64'h0);
        chk("rst_pc", {instr_pc, pc_plus8}, 64'h0);
        chk("rst_cnt", {48'h0, issued_cnt}, 64'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // straight line, zero wait, branch at 0x8 to 0x103
        br_en = 1'b1; br_pc = 32'h8; p_target = 32'h103;
        run_accepts(6, 40, "straight0");
        br_en = 1'b0;
        for (int i = 0; i < 6; i++)
            if (i < acc_log.size()) chk("accept_pc", {32'h0, acc_log[i]}, {32'h0, exp_pcs[i]});
            else timeout("accept_pc");

        // three-wait memory
        wait_cfg = 3;
        run_accepts(4, 60, "straight3");

        // backpressure
        wait_cfg = 1; p_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = instr_valid; end
        if (!seen) timeout("bp_valid_wait");
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_no_req", {63'h0, imem_req}, 64'h0);
            chk("bp_valid", {63'h0, instr_valid}, 64'h1);
        end
        p_ready = 1'b1;
        run_accepts(2, 20, "bp_release");

        // flush in S_FETCH with a response outstanding (2-wait)
        wait_cfg = 2; p_target = 32'h203; fmode = 1;
        wait_flush("flush_fetch_wait");
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("flush_no_valid", {63'h0, instr_valid}, 64'h0);
        end
        n0 = acc_log.size();
        run_accepts(1, 20, "flush_fetch_acc");
        if (acc_log.size() > n0) chk("flush_fetch_pc", {32'h0, acc_log[n0]}, 64'h200);

        // flush coinciding with the memory response
        wait_cfg = 0; p_target = 32'h280; fmode = 2;
        wait_flush("flush_resp_wait");
        cyc();
        chk("flush_resp_drop", {63'h0, instr_valid}, 64'h0);
        n0 = acc_log.size();
        run_accepts(1, 20, "flush_resp_acc");
        if (acc_log.size() > n0) chk("flush_resp_pc", {32'h0, acc_log[n0]}, 64'h280);

        // flush in S_ISSUE with ready and branch_taken: instruction dropped, flush target wins
        p_target = 32'h300; fmode = 3; br_all = 1'b1;
        wait_flush("flush_issue_wait");
        br_all = 1'b0;
        n0 = acc_log.size();
        run_accepts(1, 20, "flush_issue_acc");
        if (acc_log.size() > n0) chk("flush_issue_pc", {32'h0, acc_log[n0]}, 64'h300);

        // asynchronous reset in the middle of a 3-wait fetch
        wait_cfg = 3;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = imem_req && !drop_pending; end
        if (!seen) timeout("rst_fetch_wait");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {63'h0, imem_req}, 64'h0);
        chk("arst_valid", {63'h0, instr_valid}, 64'h0);
        chk("arst_cnt", {48'h0, issued_cnt}, 64'h0);
        imem_valid = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin cyc(); seen = imem_req; end
        if (seen) chk("arst_first_addr", {32'h0, imem_addr}, 64'h0);
        else timeout("arst_first_req");
        run_accepts(2, 30, "arst_resume");

        // PC and counter wrap on the second instance
        @(negedge clk); rst2_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin @(negedge clk); seen = imem_req2; end
        if (seen) chk("wrap_addr0", {32'h0, imem_addr2}, 64'hFFFF_FFFC);
        else timeout("wrap_req0");
        @(negedge clk);
        chk("wrap_valid", {63'h0, instr_valid2}, 64'h1);
        chk("wrap_pc", {instr_pc2, pc_plus8_2}, {32'hFFFF_FFFC, 32'h4});
        chk("wrap_fields", {32'h0, cond2, op2, funct2, rn2, rd2, imm12_2}, {32'h0, 4'hE, 2'd0, 6'h08, 4'h2, 4'h1, 12'h003});
        @(negedge clk);
        chk("wrap_addr1", {31'h0, imem_req2, imem_addr2}, {31'h0, 1'b1, 32'h0});
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = instr_valid2 && (issued_cnt2 == 4'hF);
        end
        if (!seen) timeout("wrap_cnt_wait");
        else begin
            @(negedge clk);
            chk("wrap_cnt", {60'h0, issued_cnt2}, 64'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
